// File: rtl/structs.sv
// ============================================================================
//  Module      : structs_pkg
//  Description : Shared decoded-instruction payload carried by the instruction queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package structs_pkg;

    typedef struct packed {
        logic [15:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } decoded_instr;

endpackage

`default_nettype wire

// File: rtl/instr_queue_dual.sv
// ============================================================================
//  Module      : instr_queue_dual
//  Description : Two-wide push / two-wide pop circular instruction queue.
//                Optional statistics ports enabled by macro IQ_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_queue_dual
    import structs_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                valid_i,
    input  decoded_instr        data_i,
    input  logic                valid_i_2,
    input  decoded_instr        data_i_2,
    output logic                ready_o,
    output logic                valid_o,
    output decoded_instr        data_o,
    input  logic                ready_i,
    output logic                valid_o_2,
    output decoded_instr        data_o_2,
    input  logic                ready_i_2
`ifdef IQ_STATS_EN
    ,
    output logic [$clog2(DEPTH):0] max_occ,
    output logic [15:0]         drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    decoded_instr   mem_q [DEPTH];

    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;

    logic           push1, push2, pop1, pop2;
    logic [AW-1:0]  head_nxt, tail_nxt;
    logic [AW-1:0]  wr_addr_2;

    // Registered count only, so a same-cycle pop cannot open a slot being read.
    assign ready_o   = (count_q <= CW'(DEPTH - 2));
    assign valid_o   = (count_q >= CW'(1));
    assign valid_o_2 = (count_q >= CW'(2));

    assign head_nxt  = head_q + AW'(1);
    assign tail_nxt  = tail_q + AW'(1);
    assign data_o    = mem_q[head_q];
    assign data_o_2  = mem_q[head_nxt];

    assign push1 = valid_i   & ready_o;
    assign push2 = valid_i_2 & ready_o;
    assign pop1  = ready_i   & valid_o;
    assign pop2  = ready_i_2 & valid_o_2 & pop1;

    assign wr_addr_2 = push1 ? tail_nxt : tail_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(pop1) + AW'(pop2);
            tail_d  = tail_q + AW'(push1) + AW'(push2);
            count_d = count_q + CW'(push1) + CW'(push2) - CW'(pop1) - CW'(pop2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; pointers and count alone define what is live.
    always_ff @(posedge clk) begin
        if (push1 && !flush) begin
            mem_q[tail_q] <= data_i;
        end
        if (push2 && !flush) begin
            mem_q[wr_addr_2] <= data_i_2;
        end
    end

`ifdef IQ_STATS_EN
    logic [CW-1:0]  max_occ_q, max_occ_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic [1:0]     drops;
    logic [16:0]    drop_sum;

    assign drops    = {1'b0, valid_i & ~ready_o} + {1'b0, valid_i_2 & ~ready_o};
    assign drop_sum = {1'b0, drop_cnt_q} + 17'(drops);

    always_comb begin
        max_occ_d  = (count_d > max_occ_q) ? count_d : max_occ_q;
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Statistics survive flush; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_occ_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            max_occ_q  <= max_occ_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign max_occ  = max_occ_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_queue_dual.sv
// ============================================================================
//  Module      : tb_instr_queue_dual
//  Description : Scoreboard bench for instr_queue_dual (DEPTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_queue_dual;
    import structs_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = $bits(decoded_instr);
    localparam int VW    = 3 + 2 * DW;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         valid_i = 1'b0;
    decoded_instr data_i = '0;
    logic         valid_i_2 = 1'b0;
    decoded_instr data_i_2 = '0;
    logic         ready_o;
    logic         valid_o;
    decoded_instr data_o;
    logic         ready_i = 1'b0;
    logic         valid_o_2;
    decoded_instr data_o_2;
    logic         ready_i_2 = 1'b0;
`ifdef IQ_STATS_EN
    logic [$clog2(DEPTH):0] max_occ;
    logic [15:0]            drop_cnt;
`endif

    instr_queue_dual #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .valid_i_2 (valid_i_2),
        .data_i_2  (data_i_2),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .ready_i   (ready_i),
        .valid_o_2 (valid_o_2),
        .data_o_2  (data_o_2),
        .ready_i_2 (ready_i_2)
`ifdef IQ_STATS_EN
        ,
        .max_occ   (max_occ),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    decoded_instr sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           tag = 1;
    int           m_max_occ = 0;
    int           m_drop = 0;

    function automatic decoded_instr mk(int i);
        decoded_instr d;
        d.pc     = 16'(16'h1000 + i * 4);
        d.opcode = 7'(i * 3);
        d.rd     = 5'(i);
        d.rs1    = 5'(i + 7);
        d.rs2    = 5'(i + 13);
        return d;
    endfunction

    // Expected {ready, valid, valid2, data, data2} from the scoreboard; data only when valid.
    function automatic logic [VW-1:0] exp_vec();
        decoded_instr e0, e1;
        e0 = (sb.size() >= 1) ? sb[0] : '0;
        e1 = (sb.size() >= 2) ? sb[1] : '0;
        return {((DEPTH - sb.size()) >= 2), (sb.size() >= 1), (sb.size() >= 2), e0, e1};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        decoded_instr o0, o1;
        o0 = valid_o   ? data_o   : '0;
        o1 = valid_o_2 ? data_o_2 : '0;
        return {ready_o, valid_o, valid_o_2, o0, o1};
    endfunction

    // Drives one cycle of stimulus and advances the reference model across the edge.
    task automatic step(bit v1, bit v2, bit r1, bit r2, bit fl);
        decoded_instr d1, d2;
        bit rdy, p1, p2, q1, q2;
        @(negedge clk);
        d1 = mk(tag);
        d2 = mk(tag + 1);
        tag += 2;
        valid_i = v1; data_i = d1; valid_i_2 = v2; data_i_2 = d2;
        ready_i = r1; ready_i_2 = r2; flush = fl;
        rdy = (DEPTH - sb.size()) >= 2;
        p1  = v1 && rdy;
        p2  = v2 && rdy;
        q1  = r1 && (sb.size() >= 1);
        q2  = r2 && (sb.size() >= 2) && q1;
        @(posedge clk);
        m_drop += int'(v1 && !rdy) + int'(v2 && !rdy);
        if (m_drop > 16'hFFFF) m_drop = 16'hFFFF;
        if (fl) begin
            sb.delete();
        end else begin
            if (q1) void'(sb.pop_front());
            if (q2) void'(sb.pop_front());
            if (p1) sb.push_back(d1);
            if (p2) sb.push_back(d2);
        end
        if (sb.size() > m_max_occ) m_max_occ = sb.size();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
`ifdef IQ_STATS_EN
        vectors++;
        if (max_occ !== '0 || drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_stats: got max_occ=%0d drop_cnt=%0d expected 0/0", max_occ, drop_cnt);
        end
`endif
    endtask

    task automatic test_dual_push();
        decoded_instr a, b;
        a = mk(tag);
        b = mk(tag + 1);
        step(1, 1, 0, 0, 0);
        vectors++;
        if (valid_o !== 1'b1 || data_o !== a || valid_o_2 !== 1'b1 || data_o_2 !== b) begin
            miscompares++;
            $display("FAIL dual_push: got v=%b d=%h v2=%b d2=%h expected 1 %h 1 %h",
                     valid_o, data_o, valid_o_2, data_o_2, a, b);
        end
        step(0, 0, 1, 1, 0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL dual_pop_empty: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_fill_boundary();
        int drop0;
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        vectors++;
        if (ready_o !== 1'b1 || sb.size() != 6) begin
            miscompares++;
            $display("FAIL fill6_ready: got ready_o=%b expected 1", ready_o);
        end
        step(1, 0, 0, 0, 0);
        vectors++;
        if (ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fill7_ready: got ready_o=%b expected 0", ready_o);
        end
        drop0 = m_drop;
        step(1, 1, 0, 0, 0);
        vectors++;
        if (obs_vec() !== exp_vec() || sb.size() != 7) begin
            miscompares++;
            $display("FAIL drop_at_7: got %h expected %h", obs_vec(), exp_vec());
        end
`ifdef IQ_STATS_EN
        vectors++;
        if (drop_cnt !== 16'(drop0 + 2)) begin
            miscompares++;
            $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, drop0 + 2);
        end
`endif
        step(1, 0, 1, 0, 0);
        vectors++;
        if (obs_vec() !== exp_vec() || ready_o !== 1'b1 || sb.size() != 6) begin
            miscompares++;
            $display("FAIL pop_with_push_at_7: got %h expected %h", obs_vec(), exp_vec());
        end
        while (sb.size() > 0) begin
            step(0, 0, 1, 1, 0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL drain_order: got %h expected %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            step(1, 1, i > 0, i > 0, 0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL wrap_iter%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        step(0, 0, 1, 1, 0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL wrap_drain: got %h expected %h", obs_vec(), exp_vec());
        end
`ifdef IQ_STATS_EN
        vectors++;
        if (max_occ !== 4'(m_max_occ)) begin
            miscompares++;
            $display("FAIL max_occ: got %0d expected %0d", max_occ, m_max_occ);
        end
`endif
    endtask

    task automatic test_flush();
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        vectors++;
        if (valid_o !== 1'b0 || valid_o_2 !== 1'b0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_priority: got v=%b v2=%b rdy=%b expected 0 0 1",
                     valid_o, valid_o_2, ready_o);
        end
        step(1, 0, 0, 0, 0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL push_after_flush: got %h expected %h", obs_vec(), exp_vec());
        end
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_ready2_only();
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        vectors++;
        if (obs_vec() !== exp_vec() || sb.size() != 3) begin
            miscompares++;
            $display("FAIL ready2_only: got %h expected %h", obs_vec(), exp_vec());
        end
        step(0, 0, 1, 0, 0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL single_pop: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 0, 0, 0);
        @(negedge clk);
        valid_i = 1'b0; valid_i_2 = 1'b0; ready_i = 1'b0; ready_i_2 = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_max_occ = 0;
        m_drop = 0;
        #1;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 1, 1, 0);
        vectors++;
        if (obs_vec() !== exp_vec() || sb.size() != 1) begin
            miscompares++;
            $display("FAIL after_reset: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_dual_push();
        test_wrap();
        test_fill_boundary();
        test_flush();
        test_ready2_only();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_queue_dual.md
INSTR_QUEUE_DUAL -- requirements
Module: instr_queue_dual

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of queue entries (power of two, at least 4).
REQ-002 The block SHALL carry entries of type decoded_instr from structs.sv; DW below denotes $bits(decoded_instr).
REQ-003 The block SHALL provide the following ports:
- clk  in  1  the single clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries.
- valid_i  in  1  first push request from the decoder.
- data_i  in  DW  first push payload.
- valid_i_2  in  1  second push request.
- data_i_2  in  DW  second push payload (younger than data_i).
- ready_o  out  1  at least 2 free slots.
- valid_o  out  1  head entry valid.
- data_o  out  DW  head entry.
- ready_i  in  1  issue pops the head.
- valid_o_2  out  1  head+1 entry valid.
- data_o_2  out  DW  head+1 entry.
- ready_i_2  in  1  issue pops head+1.

Function
REQ-004 The block SHALL implement a circular buffer with head and tail pointers that wrap modulo DEPTH, plus an occupancy count of width $clog2(DEPTH)+1.
REQ-005 ready_o SHALL equal (DEPTH - count) >= 2, computed from the registered count only, so that a same-cycle pop never raises it.
REQ-006 push1 = valid_i & ready_o; push2 = valid_i_2 & ready_o.
REQ-007 Push requests while ready_o=0 SHALL be dropped with no state change.
REQ-008 push1 & push2 SHALL write data_i at tail and data_i_2 at tail+1, advancing tail by 2.
REQ-009 A single push SHALL write at tail and advance tail by 1; a lone push2 writes data_i_2 at tail.
REQ-010 valid_o SHALL equal count>=1 with data_o = mem[head]; valid_o_2 SHALL equal count>=2 with data_o_2 = mem[head+1]; both are read combinationally from storage.
REQ-011 pop1 = ready_i & valid_o; pop2 = ready_i_2 & valid_o_2 & pop1; head SHALL advance by pop1+pop2.
REQ-012 ready_i_2 without pop1 SHALL be ignored.
REQ-013 Simultaneous push and pop SHALL update count by pushes minus pops in one cycle.
REQ-014 Pop and push in the same cycle SHALL never touch the same slot, guaranteed by REQ-005.
REQ-015 Latency SHALL be exactly 1 cycle: an entry written at edge N is visible on data_o/valid_o after edge N (no same-cycle bypass).
REQ-016 A full queue (count=DEPTH) SHALL hold ready_o=0; count=DEPTH-1 also yields ready_o=0.
REQ-017 An empty queue SHALL hold valid_o=valid_o_2=0; pops on an empty queue are no-ops.
REQ-018 flush SHALL reset head, tail and count to 0 at the next edge and take priority over every same-cycle push and pop.
REQ-019 Storage contents SHALL NOT require clearing on flush or reset.

Reset
REQ-020 While rst_n=0, head=tail=count=0 asynchronously, giving valid_o=0, valid_o_2=0 and ready_o=1.
REQ-021 Reset asserted mid-operation SHALL discard all entries, and the first cycle after deassertion SHALL behave as an empty queue.

Configuration
REQ-022 When macro IQ_STATS_EN is defined, the block SHALL add the following output ports:
- max_occ  out  $clog2(DEPTH)+1  high-water mark of count.
- drop_cnt  out  16  pushes dropped per REQ-007, counting 2 when both pushes drop.
REQ-023 With IQ_STATS_EN, drop_cnt SHALL saturate at 16'hFFFF, both counters SHALL reset to 0 on rst_n only (not on flush), and max_occ SHALL update at the edge where count exceeds it.
REQ-024 Without IQ_STATS_EN, these ports and registers SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-025 Reset, then dual push of A,B -> the next cycle shows valid_o=1 data_o=A, valid_o_2=1 data_o_2=B, count=2.
REQ-026 With DEPTH=8, fill to 6 entries -> ready_o=1; one further single push (7 entries) -> ready_o=0; a dual push now is dropped, and with IQ_STATS_EN drop_cnt increments by 2.
REQ-027 At count=7, pop1 plus a push attempt in the same cycle -> the push is dropped, count=6 the next cycle, and ready_o=1.
REQ-028 Cycle 16 dual pushes with dual pops at one entry of lag -> pointers wrap, data order is preserved, and max_occ reaches its expected value.
REQ-029 At count=5, flush with dual push and dual pop in the same cycle -> count=0, valid_o=0 and ready_o=1 the next cycle.
REQ-030 ready_i_2=1 with ready_i=0 at count=3 -> no pop occurs and count stays 3.
